// File: rtl/vga_timing_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : vga_timing_pkg                                             |
// | Description : 1024x768@60 timing constants and split-position compare    |
// |               helpers shared by the timing generator and the console.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package vga_timing_pkg;

  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_H_FP     = 24;
  localparam int XGA_H_SYNC   = 136;
  localparam int XGA_H_BP     = 160;
  localparam int XGA_H_TOTAL  = XGA_H_ACTIVE + XGA_H_FP + XGA_H_SYNC + XGA_H_BP;

  localparam int XGA_V_ACTIVE = 768;
  localparam int XGA_V_FP     = 3;
  localparam int XGA_V_SYNC   = 6;
  localparam int XGA_V_BP     = 29;
  localparam int XGA_V_TOTAL  = XGA_V_ACTIVE + XGA_V_FP + XGA_V_SYNC + XGA_V_BP;

  // x splits as hi*2^X_LO_W + lo, y splits as hi*Y_LO_DIV + lo
  localparam int X_LO_W   = 5;
  localparam int Y_LO_DIV = 48;

  localparam logic SYNC_NEG = 1'b0;

  // Mixed-radix "x >= constant" without rebuilding the linear coordinate
  function automatic logic x_ge(input logic [5:0] hi, input logic [4:0] lo,
                                input logic [5:0] c_hi, input logic [4:0] c_lo);
    return (hi > c_hi) || ((hi == c_hi) && (lo >= c_lo));
  endfunction

  // Mixed-radix "y >= constant"
  function automatic logic y_ge(input logic [4:0] hi, input logic [5:0] lo,
                                input logic [4:0] c_hi, input logic [5:0] c_lo);
    return (hi > c_hi) || ((hi == c_hi) && (lo >= c_lo));
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_xga_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vga_xga_timing_gen                                         |
// | Description : Free-running video timing generator with split x/y         |
// |               position (x = hi*32+lo, y = hi*48+lo), registered syncs,   |
// |               blank and a sticky start-of-vblank interrupt.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module vga_xga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = XGA_H_ACTIVE,
  parameter int   H_FP     = XGA_H_FP,
  parameter int   H_SYNC   = XGA_H_SYNC,
  parameter int   H_BP     = XGA_H_BP,
  parameter int   V_ACTIVE = XGA_V_ACTIVE,
  parameter int   V_FP     = XGA_V_FP,
  parameter int   V_SYNC   = XGA_V_SYNC,
  parameter int   V_BP     = XGA_V_BP,
  parameter logic SYNC_POL = SYNC_NEG
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cli,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic       interrupt,
  output logic [4:0] x_lo,
  output logic [5:0] x_hi,
  output logic [5:0] y_lo,
  output logic [4:0] y_hi
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int c_X_DIV   = 1 << X_LO_W;
  localparam int c_HS_ON   = H_ACTIVE + H_FP;
  localparam int c_HS_OFF  = c_HS_ON + H_SYNC;
  localparam int c_VS_ON   = V_ACTIVE + V_FP;
  localparam int c_VS_OFF  = c_VS_ON + V_SYNC;

  // All compare points pre-split into (hi, lo) so no multiplier is needed
  localparam logic [4:0] c_X_LO_LAST = 5'(c_X_DIV - 1);
  localparam logic [5:0] c_Y_LO_LAST = 6'(Y_LO_DIV - 1);
  localparam logic [5:0] c_X_END_HI  = 6'((c_H_TOTAL - 1) / c_X_DIV);
  localparam logic [4:0] c_X_END_LO  = 5'((c_H_TOTAL - 1) % c_X_DIV);
  localparam logic [4:0] c_Y_END_HI  = 5'((c_V_TOTAL - 1) / Y_LO_DIV);
  localparam logic [5:0] c_Y_END_LO  = 6'((c_V_TOTAL - 1) % Y_LO_DIV);
  localparam logic [5:0] c_HB_HI     = 6'(H_ACTIVE / c_X_DIV);
  localparam logic [4:0] c_HB_LO     = 5'(H_ACTIVE % c_X_DIV);
  localparam logic [5:0] c_HS_ON_HI  = 6'(c_HS_ON / c_X_DIV);
  localparam logic [4:0] c_HS_ON_LO  = 5'(c_HS_ON % c_X_DIV);
  localparam logic [5:0] c_HS_OFF_HI = 6'(c_HS_OFF / c_X_DIV);
  localparam logic [4:0] c_HS_OFF_LO = 5'(c_HS_OFF % c_X_DIV);
  localparam logic [4:0] c_VB_HI     = 5'(V_ACTIVE / Y_LO_DIV);
  localparam logic [5:0] c_VB_LO     = 6'(V_ACTIVE % Y_LO_DIV);
  localparam logic [4:0] c_VS_ON_HI  = 5'(c_VS_ON / Y_LO_DIV);
  localparam logic [5:0] c_VS_ON_LO  = 6'(c_VS_ON % Y_LO_DIV);
  localparam logic [4:0] c_VS_OFF_HI = 5'(c_VS_OFF / Y_LO_DIV);
  localparam logic [5:0] c_VS_OFF_LO = 6'(c_VS_OFF % Y_LO_DIV);

  logic [4:0] r_x_lo, w_x_lo_nxt;
  logic [5:0] r_x_hi, w_x_hi_nxt;
  logic [5:0] r_y_lo, w_y_lo_nxt;
  logic [4:0] r_y_hi, w_y_hi_nxt;
  logic       r_hsync, r_vsync, r_blank, r_irq;
  logic       w_hs_act, w_vs_act, w_blank_nxt, w_irq_set;

  // Next position: x mixed-radix increment, y advances on the last pixel of a line
  always_comb begin
    w_x_lo_nxt = r_x_lo + 5'd1;
    w_x_hi_nxt = r_x_hi;
    w_y_lo_nxt = r_y_lo;
    w_y_hi_nxt = r_y_hi;
    if ((r_x_hi == c_X_END_HI) && (r_x_lo == c_X_END_LO)) begin
      w_x_lo_nxt = '0;
      w_x_hi_nxt = '0;
      if ((r_y_hi == c_Y_END_HI) && (r_y_lo == c_Y_END_LO)) begin
        w_y_lo_nxt = '0;
        w_y_hi_nxt = '0;
      end else if (r_y_lo == c_Y_LO_LAST) begin
        w_y_lo_nxt = '0;
        w_y_hi_nxt = r_y_hi + 5'd1;
      end else begin
        w_y_lo_nxt = r_y_lo + 6'd1;
      end
    end else if (r_x_lo == c_X_LO_LAST) begin
      w_x_lo_nxt = '0;
      w_x_hi_nxt = r_x_hi + 6'd1;
    end
  end

  // Decode on the next position so registered flags line up with the counters
  assign w_hs_act    = x_ge(w_x_hi_nxt, w_x_lo_nxt, c_HS_ON_HI, c_HS_ON_LO) &&
                       !x_ge(w_x_hi_nxt, w_x_lo_nxt, c_HS_OFF_HI, c_HS_OFF_LO);
  assign w_vs_act    = y_ge(w_y_hi_nxt, w_y_lo_nxt, c_VS_ON_HI, c_VS_ON_LO) &&
                       !y_ge(w_y_hi_nxt, w_y_lo_nxt, c_VS_OFF_HI, c_VS_OFF_LO);
  assign w_blank_nxt = x_ge(w_x_hi_nxt, w_x_lo_nxt, c_HB_HI, c_HB_LO) ||
                       y_ge(w_y_hi_nxt, w_y_lo_nxt, c_VB_HI, c_VB_LO);
  assign w_irq_set   = (w_x_hi_nxt == 6'd0) && (w_x_lo_nxt == 5'd0) &&
                       (w_y_hi_nxt == c_VB_HI) && (w_y_lo_nxt == c_VB_LO);

  // Position counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x_lo <= '0;
      r_x_hi <= '0;
      r_y_lo <= '0;
      r_y_hi <= '0;
    end else begin
      r_x_lo <= w_x_lo_nxt;
      r_x_hi <= w_x_hi_nxt;
      r_y_lo <= w_y_lo_nxt;
      r_y_hi <= w_y_hi_nxt;
    end
  end

  // Sync and blank flags, sync level chosen by SYNC_POL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
      r_blank <= 1'b0;
    end else begin
      r_hsync <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vsync <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      r_blank <= w_blank_nxt;
    end
  end

  // Sticky vblank interrupt; a set in the same cycle as cli takes priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else if (w_irq_set) begin
      r_irq <= 1'b1;
    end else if (cli) begin
      r_irq <= 1'b0;
    end
  end

  assign hsync     = r_hsync;
  assign vsync     = r_vsync;
  assign blank     = r_blank;
  assign interrupt = r_irq;
  assign x_lo      = r_x_lo;
  assign x_hi      = r_x_hi;
  assign y_lo      = r_y_lo;
  assign y_hi      = r_y_hi;

endmodule
`default_nettype wire

// File: tb/tb_vga_xga_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_vga_xga_timing_gen                                      |
// | Description : Bench for vga_xga_timing_gen: one instance at the native   |
// |               XGA geometry, one at a compact geometry with positive sync |
// |               so that whole frames and the interrupt fit a short run.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_vga_xga_timing_gen;

  // Native geometry
  localparam int A_HA = 1024, A_HF = 24, A_HS = 136, A_HB = 160;
  localparam int A_VA = 768,  A_VF = 3,  A_VS = 6,   A_VB = 29;
  localparam logic A_POL = 1'b0;
  // Compact geometry: 112 x 112, frame = 12544 clocks
  localparam int B_HA = 70,  B_HF = 10, B_HS = 20, B_HB = 12;
  localparam int B_VA = 100, B_VF = 2,  B_VS = 3,  B_VB = 7;
  localparam logic B_POL = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, cli_a, cli_b;
  logic hs_a, vs_a, bl_a, irq_a, hs_b, vs_b, bl_b, irq_b;
  logic [4:0] xl_a, xl_b, yh_a, yh_b;
  logic [5:0] xh_a, xh_b, yl_a, yl_b;
  logic [25:0] got_a, got_b;

  assign got_a = {hs_a, vs_a, bl_a, irq_a, xh_a, xl_a, yh_a, yl_a};
  assign got_b = {hs_b, vs_b, bl_b, irq_b, xh_b, xl_b, yh_b, yl_b};

  vga_xga_timing_gen u_dut_a (
    .clk(clk), .rst(rst_a), .cli(cli_a),
    .hsync(hs_a), .vsync(vs_a), .blank(bl_a), .interrupt(irq_a),
    .x_lo(xl_a), .x_hi(xh_a), .y_lo(yl_a), .y_hi(yh_a)
  );

  vga_xga_timing_gen #(
    .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
    .SYNC_POL(B_POL)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .cli(cli_b),
    .hsync(hs_b), .vsync(vs_b), .blank(bl_b), .interrupt(irq_b),
    .x_lo(xl_b), .x_hi(xh_b), .y_lo(yl_b), .y_hi(yh_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int ta = 0;       // clocks since instance A left reset (also the run timeline)
  int tb_t = 0;     // clocks since instance B last left reset
  logic m_irq_a = 1'b0;
  logic m_irq_b = 1'b0;

  // Expected outputs at clock t after reset, from the linear position
  function automatic logic [25:0] model(input int t, input int ha, input int hf,
                                        input int hs, input int hb, input int va,
                                        input int vf, input int vs, input int vb,
                                        input logic pol, input logic irq);
    int ht, vt, p, x, y;
    logic hs_on, vs_on, bl;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    p = t % (ht * vt);
    x = p % ht;
    y = p / ht;
    hs_on = (x >= ha + hf) && (x < ha + hf + hs);
    vs_on = (y >= va + vf) && (y < va + vf + vs);
    bl = (x >= ha) || (y >= va);
    return {hs_on ? pol : ~pol, vs_on ? pol : ~pol, bl, irq,
            6'(x / 32), 5'(x % 32), 5'(y / 48), 6'(y % 48)};
  endfunction

  // True when clock t lands on the first pixel of vertical blanking
  function automatic logic at_vblank(input int t, input int ht, input int vt, input int va);
    return (t % (ht * vt)) == va * ht;
  endfunction

  task automatic chk_vec(input string name, input logic [25:0] got, input logic [25:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (ta=%0d tb=%0d)", name, got, exp, ta, tb_t);
    end
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (ta=%0d tb=%0d)", name, got, exp, ta, tb_t);
    end
  endtask

  task automatic wait_ta(input int n);
    while (ta < n) @(negedge clk);
  endtask

  // Reference model advance and per-cycle compare of both instances
  always @(posedge clk) begin
    if (rst_a) begin
      ta = 0;
      m_irq_a = 1'b0;
    end else begin
      ta++;
      if (at_vblank(ta, A_HA + A_HF + A_HS + A_HB, A_VA + A_VF + A_VS + A_VB, A_VA))
        m_irq_a = 1'b1;
      else if (cli_a)
        m_irq_a = 1'b0;
    end
    if (rst_b) begin
      tb_t = 0;
      m_irq_b = 1'b0;
    end else begin
      tb_t++;
      if (at_vblank(tb_t, B_HA + B_HF + B_HS + B_HB, B_VA + B_VF + B_VS + B_VB, B_VA))
        m_irq_b = 1'b1;
      else if (cli_b)
        m_irq_b = 1'b0;
    end
    #1;
    chk_vec("a_cycle", got_a, model(ta, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, A_POL, m_irq_a));
    chk_vec("b_cycle", got_b, model(tb_t, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, B_POL, m_irq_b));
  end

  int base;

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    cli_a = 1'b0;
    cli_b = 1'b0;
    @(negedge clk);
    // Reset state: (0,0), visible, syncs deasserted
    chk_vec("a_reset", got_a, 26'h3000000);
    chk_vec("b_reset", got_b, 26'h0000000);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // First line of A
    wait_ta(1);    chk("a_xlo_1", 8'(xl_a), 8'd1);
    wait_ta(1023); chk("a_blank_1023", 8'(bl_a), 8'd0);
    wait_ta(1024); chk("a_blank_1024", 8'(bl_a), 8'd1);
    wait_ta(1047); chk("a_hs_1047", 8'(hs_a), 8'd1);
    wait_ta(1048); chk("a_hs_1048", 8'(hs_a), 8'd0);
    wait_ta(1183); chk("a_hs_1183", 8'(hs_a), 8'd0);
    wait_ta(1184); chk("a_hs_1184", 8'(hs_a), 8'd1);
    wait_ta(1343);
    chk("a_xhi_1343", 8'(xh_a), 8'd41);
    chk("a_xlo_1343", 8'(xl_a), 8'd31);
    chk("a_blank_1343", 8'(bl_a), 8'd1);
    wait_ta(1344);
    chk_vec("a_line1", got_a, {1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 5'd0, 5'd0, 6'd1});

    // B interrupt rise at x=0, y=100 (clock 11200), then cli 10 clocks later
    wait_ta(11199); chk("b_irq_11199", 8'(irq_b), 8'd0);
    wait_ta(11200);
    chk_vec("b_vblank_start", got_b, {1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 5'd0, 5'd2, 6'd4});
    wait_ta(11209);
    chk("b_irq_11209", 8'(irq_b), 8'd1);
    cli_b = 1'b1;
    wait_ta(11210);
    cli_b = 1'b0;
    chk("b_irq_cleared", 8'(irq_b), 8'd0);

    // B vsync on lines 102..104 (positive polarity)
    wait_ta(11423); chk("b_vs_11423", 8'(vs_b), 8'd0);
    wait_ta(11424); chk("b_vs_11424", 8'(vs_b), 8'd1);
    wait_ta(11759); chk("b_vs_11759", 8'(vs_b), 8'd1);
    wait_ta(11760); chk("b_vs_11760", 8'(vs_b), 8'd0);

    // B frame wrap
    wait_ta(12543);
    chk_vec("b_last_pixel", got_b, {1'b0, 1'b0, 1'b1, 1'b0, 6'd3, 5'd15, 5'd2, 6'd15});
    wait_ta(12544);
    chk_vec("b_frame_wrap", got_b, 26'h0000000);

    // cli with no pending interrupt
    wait_ta(13000);
    cli_b = 1'b1;
    wait_ta(13001);
    cli_b = 1'b0;
    chk("b_cli_idle", 8'(irq_b), 8'd0);

    // cli sampled on the same edge as the set of frame 2: set wins
    wait_ta(23743);
    chk("b_irq_23743", 8'(irq_b), 8'd0);
    cli_b = 1'b1;
    wait_ta(23744);
    cli_b = 1'b0;
    chk("b_irq_set_wins", 8'(irq_b), 8'd1);
    wait_ta(23745);
    chk("b_irq_held", 8'(irq_b), 8'd1);

    // Mid-frame asynchronous reset at y=40, x=50 of frame 3
    wait_ta(29618);
    chk("b_yhi_mid", 8'(yh_b), 8'd0);
    chk("b_ylo_mid", 8'(yl_b), 8'd40);
    chk("b_xhi_mid", 8'(xh_b), 8'd1);
    chk("b_xlo_mid", 8'(xl_b), 8'd18);
    chk("b_irq_pending", 8'(irq_b), 8'd1);
    rst_b = 1'b1;
    #1;
    chk_vec("b_async_reset", got_b, 26'h0000000);
    wait_ta(29621);
    rst_b = 1'b0;
    base = ta;
    wait_ta(base + 5);
    chk_vec("b_restart", got_b, {1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 5'd5, 5'd0, 6'd0});

    // A: 48th line boundary carries y_lo into y_hi with the x wrap
    wait_ta(64511);
    chk_vec("a_before_ywrap", got_a, {1'b1, 1'b1, 1'b1, 1'b0, 6'd41, 5'd31, 5'd0, 6'd47});
    wait_ta(64512);
    chk_vec("a_ywrap", got_a, {1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 5'd0, 5'd1, 6'd0});

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
